// File: rtl/mem0_dreq_ctrl.sv
// MEM0 data-request controller: issues one cache/uncached-bridge request per memory
// instruction, stalls MEM0 until it completes, and drains responses orphaned by a flush.
// Optional CACHE instruction support is enabled by defining MEM0_CACHE_OP_EN.
module mem0_dreq_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  MEM0_wr,
  input  logic                  MEM0_mem_rd,
  input  logic                  MEM0_mem_wr,
  input  logic [1:0]            MEM0_mem_size,
  input  logic [ADDR_W-1:0]     MEM0_paddr,
  input  logic [DATA_W-1:0]     MEM0_rf_data,
  input  logic                  MEM0_unhit,
  input  logic [4:0]            MEM0_cache_op,
  input  logic                  MEM0_ex,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [DATA_W-1:0]     data_wdata,
  output logic [DATA_W/8-1:0]   data_wstrb,
  output logic                  data_uncached,
  output logic [4:0]            data_cache_op,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_W-1:0]     data_rdata,
  output logic                  MEM0_stall,
  output logic [DATA_W-1:0]     MEM0_rdata,
  output logic                  MEM0_rdata_vld,
  output logic [2:0]            dbg_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  // Handshake: a request is transferred on a cycle where data_req and data_addr_ok are
  // both high; its completion is the later (or same) cycle with data_data_ok high.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    CANCEL = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   capture;
  logic   cop_act;
  logic [4:0] cop_val;
  logic   need;
  logic   store_act;
  logic   is_req;
  logic [OFF_W-1:0]  off;
  logic [STRB_W-1:0] strb;
  logic [DATA_W-1:0] wdata;

`ifdef MEM0_CACHE_OP_EN
  assign cop_act = (MEM0_cache_op != 5'd0);
  assign cop_val = MEM0_cache_op;
`else
  logic unused_cache_op;
  assign cop_act         = 1'b0;
  assign cop_val         = 5'd0;
  assign unused_cache_op = ^MEM0_cache_op;
`endif

  assign need      = (MEM0_mem_rd | MEM0_mem_wr | cop_act) & ~MEM0_ex;
  assign store_act = MEM0_mem_wr & ~cop_act;
  assign is_req    = (state == REQ);
  assign off       = MEM0_paddr[OFF_W-1:0];

  always_comb begin
    strb  = '1;
    wdata = MEM0_rf_data;
    case (MEM0_mem_size)
      2'd0: begin
        strb  = {{(STRB_W-1){1'b0}}, 1'b1} << off;
        wdata = {STRB_W{MEM0_rf_data[7:0]}};
      end
      2'd1: begin
        strb  = {{(STRB_W-2){1'b0}}, 2'b11} << off;
        wdata = {(STRB_W/2){MEM0_rf_data[15:0]}};
      end
      default: begin
        strb  = '1;
        wdata = MEM0_rf_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      MEM0_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (capture) MEM0_rdata <= data_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (need && !flush) state_nxt = REQ;
      end
      REQ: begin
        if (flush) begin
          // Accepted but flushed: the response still has to be drained in CANCEL.
          if (data_addr_ok && !data_data_ok) state_nxt = CANCEL;
          else                               state_nxt = IDLE;
        end else if (data_addr_ok && data_data_ok) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end else if (data_addr_ok) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          state_nxt = data_data_ok ? IDLE : CANCEL;
        end else if (data_data_ok) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end
      end
      CANCEL: begin
        if (data_data_ok) state_nxt = IDLE;
      end
      DONE: begin
        if (MEM0_wr || flush) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign data_req       = is_req;
  assign data_wr        = is_req & store_act;
  assign data_size      = is_req ? MEM0_mem_size : 2'd0;
  assign data_addr      = is_req ? MEM0_paddr : '0;
  assign data_wdata     = is_req ? wdata : '0;
  assign data_wstrb     = (is_req && store_act) ? strb : '0;
  assign data_uncached  = is_req & MEM0_unhit;
  assign data_cache_op  = is_req ? cop_val : 5'd0;

  assign MEM0_stall     = (need && (state != DONE) && !flush) || (state == CANCEL);
  assign MEM0_rdata_vld = (state == DONE) && MEM0_mem_rd && !cop_act;
  assign dbg_state      = state;

endmodule
